spi_reg_bridge: RTL and testbench

//  SPI-slave front end between the uio pins and the project core: deserialises 2-byte
//  SPI transactions and exposes a bank of NUM_REGS 8-bit control registers to the core.

---
 rtl/spi_reg_bridge_pkg.sv | 9 +
 rtl/spi_reg_bridge_sync_edge.sv | 32 +++
 rtl/spi_reg_bridge.sv | 158 +++++++++++++++
 tb/tb_spi_reg_bridge.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bridge_pkg.sv
// Shared FSM state type and frame constants for the SPI register bridge.
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  localparam int CMD_RW_BIT = 7;
  localparam int FRAME_BITS = 8;

endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses
// derived from the synchronised level.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= {STAGES{RESET_VAL}};
      q_prev <= RESET_VAL;
    end else begin
      sync   <= {sync[STAGES-2:0], d};
      q_prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_prev;
  assign fall = ~q & q_prev;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 2-byte frames (cmd, data) into reads and writes of a
// small bank of 8-bit control registers, all in the system clock domain.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS    = 8,
  parameter int ADDR_W      = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  spi_sck,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  wr_strobe,
  output logic [ADDR_W-1:0]     wr_addr
);

  localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

  logic sck_rise, sck_fall, sck_unused;
  logic cs_n_sync, cs_rise_unused, cs_fall_unused;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic mosi_sync;
  logic sel, sel_d, sel_rise;

  state_t state, next_state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        rx_next, tx_shift;
  logic              rw;
  logic [ADDR_W-1:0] addr, cmd_addr;
  logic [7:0]        regs [NUM_REGS];
  logic clr_cnt, shift_in, cmd_done, data_done, miso_shift, do_write;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_sck),
    .q(sck_unused), .rise(sck_rise), .fall(sck_fall)
  );

  // cs_n resets high so that leaving reset never looks like a select.
  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .rst_n(rst_n), .d(spi_cs_n),
    .q(cs_n_sync), .rise(cs_rise_unused), .fall(cs_fall_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_pipe <= '0;
      sel_d     <= 1'b0;
    end else begin
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
      sel_d     <= sel;
    end
  end

  assign mosi_sync   = mosi_pipe[SYNC_STAGES-1];
  assign sel         = ~cs_n_sync & ena;
  assign sel_rise    = sel & ~sel_d;
  assign spi_miso_oe = sel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Deselect wins over everything, including a 16th edge seen in the same cycle.
  always_comb begin
    next_state = state;
    if (!sel) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (sel_rise)  next_state = CMD;
        CMD:     if (cmd_done)  next_state = DATA;
        DATA:    if (data_done) next_state = DONE;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    clr_cnt    = 1'b0;
    shift_in   = 1'b0;
    cmd_done   = 1'b0;
    data_done  = 1'b0;
    miso_shift = 1'b0;
    if (sel) begin
      case (state)
        IDLE: clr_cnt = sel_rise;
        CMD: begin
          shift_in = sck_rise;
          cmd_done = sck_rise && (bit_cnt == LAST_BIT);
        end
        DATA: begin
          shift_in   = sck_rise;
          data_done  = sck_rise && (bit_cnt == LAST_BIT);
          miso_shift = sck_fall;
        end
        default: ;
      endcase
    end
  end

  assign rx_next  = {rx_shift, mosi_sync};
  assign cmd_addr = rx_next[ADDR_W-1:0];
  assign do_write = data_done & rw & in_range(addr);

  // Write frames and out-of-range reads shift out zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rw        <= 1'b0;
      addr      <= '0;
      spi_miso  <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      wr_strobe <= do_write;
      if (clr_cnt)       bit_cnt <= '0;
      else if (shift_in) bit_cnt <= bit_cnt + 3'd1;
      if (shift_in) rx_shift <= rx_next[6:0];
      if (cmd_done) begin
        rw       <= rx_next[CMD_RW_BIT];
        addr     <= cmd_addr;
        tx_shift <= (!rx_next[CMD_RW_BIT] && in_range(cmd_addr)) ? regs[cmd_addr] : 8'h00;
      end else if (miso_shift) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      if (miso_shift)         spi_miso <= tx_shift[7];
      else if (state != DATA) spi_miso <= 1'b0;
      if (do_write) wr_addr <= addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (do_write) begin
      regs[addr] <= rx_next;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: stimulus queues expected writes and MISO bytes,
// independent monitors pop and compare when the DUT strobes or a frame's byte1 completes.
module tb_spi_reg_bridge;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;
  localparam int HALF     = 8;

  logic clk = 1'b0;
  logic rst_n, ena, spi_sck, spi_cs_n, spi_mosi;
  logic spi_miso, spi_miso_oe, wr_strobe;
  logic [8*NUM_REGS-1:0] reg_q;
  logic [ADDR_W-1:0]     wr_addr;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_rd[$];

  always #5 clk = ~clk;

  spi_reg_bridge #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_q(reg_q), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushWrite(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_wr.push_back(e);
  endtask

  // Drives nbits of {cmd, data, 0x00} MSB first, mode 0, then deselects.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] data,
                               input int nbits);
    logic [23:0] bits;
    bits = {cmd, data, 8'h00};
    @(negedge clk);
    spi_cs_n = 1'b0;
    waitClk(HALF);
    checkOutput("miso_oe_in_frame", 64'(spi_miso_oe), 64'(ena));
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = bits[23-i];
      waitClk(HALF);
      spi_sck = 1'b1;
      waitClk(HALF);
      spi_sck = 1'b0;
    end
    waitClk(HALF);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    waitClk(2*HALF);
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rst_n === 1'b1 && wr_strobe === 1'b1) begin
      if (exp_wr.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL wr_strobe_unexpected: got strobe at addr %0d expected none", wr_addr);
      end else begin
        e = exp_wr.pop_front();
        checkOutput("wr_addr", 64'(wr_addr), 64'(e.addr));
        checkOutput("wr_data", 64'(reg_q[8*e.addr +: 8]), 64'(e.data));
      end
    end
  end

  // Collects MISO on the master's sampling edges during byte1 of each full frame.
  initial begin : miso_mon
    int         cnt;
    logic [7:0] b;
    forever begin
      @(negedge spi_cs_n);
      cnt = 0;
      b   = 8'h00;
      while (spi_cs_n === 1'b0) begin
        @(posedge spi_sck or posedge spi_cs_n);
        if (spi_cs_n === 1'b0 && spi_sck === 1'b1) begin
          if (cnt >= 8 && cnt < 16) b = {b[6:0], spi_miso};
          cnt++;
          if (cnt == 16) begin
            if (exp_rd.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL miso_byte_unexpected: got 0x%0h expected no frame", b);
            end else begin
              checkOutput("miso_byte", 64'(b), 64'(exp_rd.pop_front()));
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n    = 1'b0;
    ena      = 1'b1;
    spi_sck  = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    waitClk(4);
    checkOutput("rst_reg_q", reg_q, 64'h0);
    checkOutput("rst_miso", 64'(spi_miso), 64'h0);
    checkOutput("rst_miso_oe", 64'(spi_miso_oe), 64'h0);
    checkOutput("rst_wr_strobe", 64'(wr_strobe), 64'h0);
    checkOutput("rst_wr_addr", 64'(wr_addr), 64'h0);
    rst_n = 1'b1;
    waitClk(4);

    $display("[TB] write reg3 = 0xA5");
    pushWrite(3'd3, 8'hA5);
    exp_rd.push_back(8'h00);
    applyStimulus(8'h83, 8'hA5, 16);
    checkOutput("t1_reg_q", reg_q, 64'h00000000_A5000000);

    $display("[TB] read reg3");
    exp_rd.push_back(8'hA5);
    applyStimulus(8'h03, 8'h00, 16);
    checkOutput("t2_reg_q", reg_q, 64'h00000000_A5000000);

    $display("[TB] aborted write to reg1, then full write");
    applyStimulus(8'h81, 8'h3C, 12);
    checkOutput("t3_abort_reg_q", reg_q, 64'h00000000_A5000000);
    pushWrite(3'd1, 8'h3C);
    exp_rd.push_back(8'h00);
    applyStimulus(8'h81, 8'h3C, 16);
    checkOutput("t3_reg_q", reg_q, 64'h00000000_A5003C00);

    $display("[TB] write reg2 with trailing extra byte");
    pushWrite(3'd2, 8'hFF);
    exp_rd.push_back(8'h00);
    applyStimulus(8'h82, 8'hFF, 24);
    checkOutput("t4_reg_q", reg_q, 64'h00000000_A5FF3C00);

    $display("[TB] reset during byte1 of a write");
    exp_rd.push_back(8'h00);
    fork
      applyStimulus(8'h84, 8'h77, 16);
      begin
        waitClk(2*HALF*12);
        rst_n = 1'b0;
        waitClk(2);
        checkOutput("t5_rst_reg_q", reg_q, 64'h0);
        checkOutput("t5_rst_miso", 64'(spi_miso), 64'h0);
        checkOutput("t5_rst_miso_oe", 64'(spi_miso_oe), 64'h0);
        checkOutput("t5_rst_wr_addr", 64'(wr_addr), 64'h0);
        checkOutput("t5_rst_wr_strobe", 64'(wr_strobe), 64'h0);
        rst_n = 1'b1;
      end
    join
    checkOutput("t5_reg_q", reg_q, 64'h0);

    $display("[TB] write with ena low, then ena high");
    ena = 1'b0;
    exp_rd.push_back(8'h00);
    applyStimulus(8'h85, 8'h5A, 16);
    checkOutput("t6_ena0_reg_q", reg_q, 64'h0);
    ena = 1'b1;
    pushWrite(3'd5, 8'h5A);
    exp_rd.push_back(8'h00);
    applyStimulus(8'h85, 8'h5A, 16);
    checkOutput("t6_reg_q", reg_q, 64'h00005A00_00000000);

    $display("[TB] read reg5 with reserved bits set");
    exp_rd.push_back(8'h5A);
    applyStimulus(8'h7D, 8'h00, 16);
    checkOutput("t7_reg_q", reg_q, 64'h00005A00_00000000);

    waitClk(10);
    checkOutput("wr_queue_drained", 64'(exp_wr.size()), 64'h0);
    checkOutput("rd_queue_drained", 64'(exp_rd.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
